// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: obstacle slot allocation, placement, scrolling and pass scoring (optional OBSTACLE_SPEEDUP_EN)
module obstacle_scheduler #(
  parameter int NUM_SLOTS = 10,
  parameter int SPAWN_X = 640,
  parameter int OBS_W = 40,
  parameter int SCROLL_SPEED = 4,
  parameter int FIRST_DELAY = 60,
  parameter int MIN_GAP = 40,
  parameter int UPPER_BOUND = 20,
  parameter int LOWER_BOUND = 460,
  parameter int MIN_H = 40,
  parameter int MAX_H = 160,
  parameter int PLAYER_X_LEFT = 160,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     gamemode,
  output logic [NUM_SLOTS-1:0][9:0]      obstacle_x_left,
  output logic [NUM_SLOTS-1:0][9:0]      obstacle_x_right,
  output logic [NUM_SLOTS-1:0][8:0]      obstacle_y_up,
  output logic [NUM_SLOTS-1:0][8:0]      obstacle_y_down,
  output logic [NUM_SLOTS-1:0]           active,
  output logic [15:0]                    score,
  output logic                           spawn_stall
);
  localparam int IW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam int TW = 8;
  typedef enum logic [1:0] {CLEAR, RUN, HOLD} mode_e;
  mode_e mode;
  logic [NUM_SLOTS-1:0][9:0] xl_q, xl_d, xr_q, xr_d;
  logic [NUM_SLOTS-1:0][8:0] yu_q, yu_d, yd_q, yd_d;
  logic [NUM_SLOTS-1:0] active_q, active_d, passed_q, passed_d;
  logic [15:0] score_q, score_d, lfsr_q, lfsr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic stall_q, stall_d;
  logic [9:0] speed;
  logic [7:0] h_raw, h;
  logic [CW-1:0] pass_cnt;
  logic [16:0] score_sum;
  logic has_free;
  logic [IW-1:0] free_idx;
`ifdef OBSTACLE_SPEEDUP_EN
  logic [4:0] raw_speed;
  assign raw_speed = 5'(SCROLL_SPEED) + {1'b0, score_q[7:4]};
  assign speed = (raw_speed > 5'd8) ? 10'd8 : 10'(raw_speed);
`else
  assign speed = 10'(SCROLL_SPEED);
`endif
  assign h_raw = 8'(MIN_H) + {1'b0, lfsr_q[6:0]};
  assign h = (h_raw > 8'(MAX_H)) ? 8'(MAX_H) : h_raw;
  assign obstacle_x_left = xl_q;
  assign obstacle_x_right = xr_q;
  assign obstacle_y_up = yu_q;
  assign obstacle_y_down = yd_q;
  assign active = active_q;
  assign score = score_q;
  assign spawn_stall = stall_q;
  // decode the game mode straight from the input so CLEAR/HOLD act on the same edge
  always_comb begin
    mode = (gamemode == 2'b00) ? CLEAR : (gamemode == 2'b01) ? RUN : HOLD;
  end
  // one RUN frame of scroll, free, score and spawn; CLEAR overrides with init values
  always_comb begin
    xl_d = xl_q;
    xr_d = xr_q;
    yu_d = yu_q;
    yd_d = yd_q;
    active_d = active_q;
    passed_d = passed_q;
    timer_d = timer_q;
    stall_d = 1'b0;
    pass_cnt = '0;
    has_free = 1'b0;
    free_idx = '0;
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (active_q[i]) begin
        if (xr_q[i] <= speed) begin
          xl_d[i] = '0;
          xr_d[i] = '0;
          yu_d[i] = '0;
          yd_d[i] = '0;
          active_d[i] = 1'b0;
          passed_d[i] = 1'b0;
        end else begin
          xr_d[i] = xr_q[i] - speed;
          xl_d[i] = (xl_q[i] < speed) ? '0 : xl_q[i] - speed;
          if (!passed_q[i] && xr_d[i] < 10'(PLAYER_X_LEFT)) begin
            passed_d[i] = 1'b1;
            pass_cnt = pass_cnt + CW'(1);
          end
        end
      end
    end
    if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end else if (has_free) begin
      active_d[free_idx] = 1'b1;
      passed_d[free_idx] = 1'b0;
      xl_d[free_idx] = 10'(SPAWN_X);
      xr_d[free_idx] = 10'(SPAWN_X + OBS_W);
      yu_d[free_idx] = lfsr_q[15] ? 9'(LOWER_BOUND) - {1'b0, h} : 9'(UPPER_BOUND);
      yd_d[free_idx] = lfsr_q[15] ? 9'(LOWER_BOUND) : 9'(UPPER_BOUND) + {1'b0, h};
      timer_d = TW'(MIN_GAP) + {3'b000, lfsr_q[4:0]};
    end else begin
      stall_d = 1'b1;
    end
    score_sum = {1'b0, score_q} + 17'(pass_cnt);
    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    if (mode == CLEAR) begin
      xl_d = '0;
      xr_d = '0;
      yu_d = '0;
      yd_d = '0;
      active_d = '0;
      passed_d = '0;
      score_d = '0;
      stall_d = 1'b0;
      timer_d = TW'(FIRST_DELAY);
      lfsr_d = LFSR_SEED;
    end
  end
  // state registers: async reset, frozen in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xl_q <= '0;
      xr_q <= '0;
      yu_q <= '0;
      yd_q <= '0;
      active_q <= '0;
      passed_q <= '0;
      score_q <= '0;
      stall_q <= 1'b0;
      timer_q <= TW'(FIRST_DELAY);
      lfsr_q <= LFSR_SEED;
    end else if (mode != HOLD) begin
      xl_q <= xl_d;
      xr_q <= xr_d;
      yu_q <= yu_d;
      yd_q <= yd_d;
      active_q <= active_d;
      passed_q <= passed_d;
      score_q <= score_d;
      stall_q <= stall_d;
      timer_q <= timer_d;
      lfsr_q <= lfsr_d;
    end
  end
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed checks of spawn timing, scrolling, hold, stall, clear and async reset
module tb_obstacle_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] gm, gm2;
  logic [9:0][9:0] xl, xr, xl2, xr2;
  logic [9:0][8:0] yu, yd, yu2, yd2;
  logic [9:0] act, act2;
  logic [15:0] sc, sc2;
  logic st, st2;
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] l60, l1;
  int g;

  always #5 clk = ~clk;

  obstacle_scheduler dut (
    .clk(clk), .rst_n(rst_n), .gamemode(gm),
    .obstacle_x_left(xl), .obstacle_x_right(xr),
    .obstacle_y_up(yu), .obstacle_y_down(yd),
    .active(act), .score(sc), .spawn_stall(st)
  );

  obstacle_scheduler #(.MIN_GAP(1), .SCROLL_SPEED(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .gamemode(gm2),
    .obstacle_x_left(xl2), .obstacle_x_right(xr2),
    .obstacle_y_up(yu2), .obstacle_y_down(yd2),
    .active(act2), .score(sc2), .spawn_stall(st2)
  );

  function automatic logic [15:0] lfsr_at(int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l;
  endfunction

  function automatic logic [8:0] exp_yu(logic [15:0] l);
    int h;
    h = 40 + int'(l[6:0]);
    if (h > 160) h = 160;
    return l[15] ? 9'(460 - h) : 9'd20;
  endfunction

  function automatic logic [8:0] exp_yd(logic [15:0] l);
    int h;
    h = 40 + int'(l[6:0]);
    if (h > 160) h = 160;
    return l[15] ? 9'd460 : 9'(20 + h);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gm = 2'b00;
    gm2 = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (act !== 10'd0 || sc !== 16'd0 || st !== 1'b0) begin n_err++; $display("FAIL reset_outputs: got act=%h score=%0d stall=%b want 0/0/0", act, sc, st); end
    n_cmp++; if (xl[0] !== 10'd0 || xr[9] !== 10'd0 || yu[3] !== 9'd0 || yd[5] !== 9'd0) begin n_err++; $display("FAIL reset_coords: got nonzero coordinates want 0"); end
    n_cmp++; if (dut.lfsr_q !== 16'hACE1 || dut.timer_q !== 8'd60) begin n_err++; $display("FAIL reset_state: got lfsr=%h timer=%0d want ace1/60", dut.lfsr_q, dut.timer_q); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_spawn();
    gm = 2'b01;
    l60 = lfsr_at(60);
    repeat (60) step();
    n_cmp++; if (act !== 10'd0) begin n_err++; $display("FAIL pre_spawn_active: got %h want 000", act); end
    step();
    n_cmp++; if (act !== 10'd1 || xl[0] !== 10'd640 || xr[0] !== 10'd680) begin n_err++; $display("FAIL first_spawn: got act=%h xl=%0d xr=%0d want 001/640/680", act, xl[0], xr[0]); end
    n_cmp++; if (yu[0] !== exp_yu(l60) || yd[0] !== exp_yd(l60)) begin n_err++; $display("FAIL first_spawn_y: got %0d/%0d want %0d/%0d", yu[0], yd[0], exp_yu(l60), exp_yd(l60)); end
    step();
    n_cmp++; if (act !== 10'd1 || xl[0] !== 10'd636 || xr[0] !== 10'd676) begin n_err++; $display("FAIL first_scroll: got act=%h xl=%0d xr=%0d want 001/636/676", act, xl[0], xr[0]); end
  endtask

  task automatic test_hold();
    repeat (9) step();
    n_cmp++; if (xl[0] !== 10'd600) begin n_err++; $display("FAIL pre_hold_x: got %0d want 600", xl[0]); end
    gm = 2'b10;
    repeat (50) step();
    n_cmp++; if (xl[0] !== 10'd600 || xr[0] !== 10'd640 || act !== 10'd1 || sc !== 16'd0) begin n_err++; $display("FAIL hold_frozen: got xl=%0d xr=%0d act=%h score=%0d want 600/640/001/0", xl[0], xr[0], act, sc); end
    n_cmp++; if (dut.timer_q !== 8'(40 + int'(l60[4:0]) - 10)) begin n_err++; $display("FAIL hold_timer: got %0d want %0d", dut.timer_q, 40 + int'(l60[4:0]) - 10); end
    gm = 2'b01;
    step();
    n_cmp++; if (xl[0] !== 10'd596 || xr[0] !== 10'd636) begin n_err++; $display("FAIL hold_resume: got %0d/%0d want 596/636", xl[0], xr[0]); end
  endtask

  task automatic test_scroll_free();
    g = 40 + int'(l60[4:0]);
    l1 = lfsr_at(61 + g);
    for (int k = 12; k <= 170; k++) begin
      step();
      if (k == g) begin
        n_cmp++; if (act[1] !== 1'b0) begin n_err++; $display("FAIL slot1_early: got %b want 0", act[1]); end
      end
      if (k == g + 1) begin
        n_cmp++; if (act[1] !== 1'b1 || xl[1] !== 10'd640 || yu[1] !== exp_yu(l1) || yd[1] !== exp_yd(l1)) begin n_err++; $display("FAIL slot1_spawn: got act=%b xl=%0d y=%0d/%0d want 1/640/%0d/%0d", act[1], xl[1], yu[1], yd[1], exp_yu(l1), exp_yd(l1)); end
      end
      if (k == 130) begin
        n_cmp++; if (sc !== 16'd0 || xr[0] !== 10'd160) begin n_err++; $display("FAIL pre_pass: got score=%0d xr=%0d want 0/160", sc, xr[0]); end
      end
      if (k == 131) begin
        n_cmp++; if (sc !== 16'd1 || xr[0] !== 10'd156) begin n_err++; $display("FAIL pass_score: got score=%0d xr=%0d want 1/156", sc, xr[0]); end
      end
      if (k == 169) begin
        n_cmp++; if (act[0] !== 1'b1 || xr[0] !== 10'd4 || xl[0] !== 10'd0) begin n_err++; $display("FAIL pre_free: got act=%b xr=%0d xl=%0d want 1/4/0", act[0], xr[0], xl[0]); end
      end
      if (k == 170) begin
        n_cmp++; if (act[0] !== 1'b0 || xr[0] !== 10'd0 || yu[0] !== 9'd0 || yd[0] !== 9'd0 || sc !== 16'd1) begin n_err++; $display("FAIL free_slot0: got act=%b xr=%0d y=%0d/%0d score=%0d want 0/0/0/0/1", act[0], xr[0], yu[0], yd[0], sc); end
      end
    end
  endtask

  task automatic test_stall();
    gm2 = 2'b01;
    for (int r = 1; r <= 742; r++) begin
      step();
      if (r == 740) begin
        n_cmp++; if (act2 !== 10'h3FF || st2 !== 1'b1) begin n_err++; $display("FAIL stall_full: got act=%h stall=%b want 3ff/1", act2, st2); end
      end
      if (r == 741) begin
        n_cmp++; if (act2 !== 10'h3FE || st2 !== 1'b1 || dut2.timer_q !== 8'd0) begin n_err++; $display("FAIL stall_freed: got act=%h stall=%b timer=%0d want 3fe/1/0", act2, st2, dut2.timer_q); end
      end
      if (r == 742) begin
        n_cmp++; if (act2 !== 10'h3FF || xl2[0] !== 10'd640 || xr2[0] !== 10'd680 || st2 !== 1'b0) begin n_err++; $display("FAIL stall_respawn: got act=%h xl=%0d xr=%0d stall=%b want 3ff/640/680/0", act2, xl2[0], xr2[0], st2); end
      end
    end
  endtask

  task automatic test_clear();
    n_cmp++; if (act === 10'd0 || sc === 16'd0) begin n_err++; $display("FAIL pre_clear: got act=%h score=%0d want nonzero", act, sc); end
    gm = 2'b00;
    step();
    n_cmp++; if (act !== 10'd0 || sc !== 16'd0 || xl !== '0 || xr !== '0 || yu !== '0 || yd !== '0) begin n_err++; $display("FAIL clear_outputs: got act=%h score=%0d want 0", act, sc); end
    n_cmp++; if (dut.lfsr_q !== 16'hACE1 || dut.timer_q !== 8'd60) begin n_err++; $display("FAIL clear_state: got lfsr=%h timer=%0d want ace1/60", dut.lfsr_q, dut.timer_q); end
  endtask

  task automatic test_async_reset();
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (act2 !== 10'd0 || sc2 !== 16'd0 || st2 !== 1'b0 || xl2 !== '0 || yd2 !== '0) begin n_err++; $display("FAIL async_reset: got act=%h score=%0d stall=%b want 0", act2, sc2, st2); end
    n_cmp++; if (dut2.lfsr_q !== 16'hACE1 || dut2.timer_q !== 8'd60) begin n_err++; $display("FAIL async_state: got lfsr=%h timer=%0d want ace1/60", dut2.lfsr_q, dut2.timer_q); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_hold();
    test_scroll_free();
    test_stall();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
